// File: rtl/matrix_feeder.sv
// Holds operand matrices A and B and streams N column/row word pairs for C = A x B.
// First push one cycle after start is sampled; i_hold stalls FEED without gaps; o_done follows DRAIN_CYC+1 cycles later.
module matrix_feeder #(
  parameter int DATA_W    = 8,
  parameter int N         = 3,
  parameter int DRAIN_CYC = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic                i_wr_sel,
  input  logic [3:0]          i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic                i_start,
  input  logic                i_hold,
  output logic [N*DATA_W-1:0] o_A,
  output logic [N*DATA_W-1:0] o_B,
  output logic                o_push,
  output logic                o_busy,
  output logic                o_done
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-1:0]   mem_a_q [N*N];
  logic [DATA_W-1:0]   mem_b_q [N*N];
  logic [N*DATA_W-1:0] a_q, b_q;
  logic [N*DATA_W-1:0] col_a_d, row_b_d;
  logic                push_q, busy_q, done_q;
  logic                wr_ok;

  assign wr_ok = i_wr_en && (int'(i_wr_addr) < N*N);

  // Column k of A and row k of B, selected from the element arrays.
  always_comb begin
    col_a_d = '0;
    row_b_d = '0;
    for (int c = 0; c < N; c++) begin
      if (k_q == KW'(c)) begin
        for (int i = 0; i < N; i++) begin
          col_a_d[i*DATA_W +: DATA_W] = mem_a_q[i*N + c];
          row_b_d[i*DATA_W +: DATA_W] = mem_b_q[c*N + i];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      push_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int e = 0; e < N*N; e++) begin
        mem_a_q[e] <= '0;
        mem_b_q[e] <= '0;
      end
    end else begin
      push_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          for (int e = 0; e < N*N; e++) begin
            if (wr_ok && i_wr_addr == 4'(e)) begin
              if (i_wr_sel) mem_b_q[e] <= i_wr_data;
              else          mem_a_q[e] <= i_wr_data;
            end
          end
          if (i_start) begin
            state_q <= FEED;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        FEED: begin
          if (!i_hold) begin
            a_q    <= col_a_d;
            b_q    <= row_b_d;
            push_q <= 1'b1;
            if (k_q == KW'(N-1)) begin
              state_q <= DRAIN;
              cnt_q   <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        DRAIN: begin
          if (cnt_q == CW'(DRAIN_CYC-1)) state_q <= DONE;
          else                           cnt_q   <= cnt_q + CW'(1);
        end
        DONE: begin
          // busy stays high through the done pulse and drops on the following edge.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_A    = a_q;
  assign o_B    = b_q;
  assign o_push = push_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
